// File: rtl/alimentador_instrucoes.sv
// ============================================================================
// Module      : alimentador_instrucoes
// Description : Instruction feeder for processador_multiciclo. It holds a
//               loadable program memory and issues one Run pulse per
//               instruction, followed by the immediate word for mvi. It then
//               waits for Done before issuing the next instruction.
//               Optional macro FEEDER_WATCHDOG_EN adds a Done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alimentador_instrucoes #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_IMM       = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [2:0]    c_OP_MVI = 3'b001;
  localparam logic [ADDR_W:0] c_ONE  = (ADDR_W+1)'(1);

  if (DATA_W < 9 || WDOG_CYCLES < 1) begin : g_param_check
    $error("alimentador_instrucoes: DATA_W must be >= 9 and WDOG_CYCLES >= 1");
  end

  state_t              r_state;
  // One extra bit so a full-depth program reaches pc==len without wrapping.
  logic [ADDR_W:0]     r_pc;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic [ADDR_W:0]     w_pc_inc;
  logic [ADDR_W:0]     w_target_pc;
  logic [ADDR_W:0]     w_target_len;
  logic                w_launch;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_imm_word;
  logic                w_issue_missing;
  logic                w_cur_missing;
  logic                w_at_end;
  logic                w_wdog_trip;

  assign pc       = r_pc[ADDR_W-1:0];
  assign w_pc_inc = r_pc + c_ONE;

  // Launch = next-issue decision: from start, from Done in IMM or WAIT_DONE.
  always_comb begin
    w_target_pc  = r_pc;
    w_target_len = r_len;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_target_pc  = '0;
        w_target_len = prog_len;
        w_launch     = start;
      end
      S_IMM: begin
        w_target_pc = w_pc_inc;
        w_launch    = Done;
      end
      S_WAIT_DONE: w_launch = Done;
      default: ;
    endcase
  end

  assign w_word          = r_mem[w_target_pc[ADDR_W-1:0]];
  assign w_imm_word      = r_mem[w_pc_inc[ADDR_W-1:0]];
  assign w_at_end        = (w_target_pc == w_target_len);
  assign w_issue_missing = (w_word[8:6] == c_OP_MVI) && (w_target_pc == w_target_len - c_ONE);
  assign w_cur_missing   = (DIN[8:6] == c_OP_MVI) && (r_pc == r_len - c_ONE);

  always_ff @(posedge Clock) begin
    if (ld_en && (r_state == S_IDLE || r_state == S_HALT)) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);

  logic [c_WDOG_W-1:0] r_wdog;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wdog <= '0;
    end else if (r_state != S_WAIT_DONE) begin
      r_wdog <= '0;
    end else if (!Done) begin
      r_wdog <= r_wdog + c_WDOG_W'(1);
    end
  end

  assign w_wdog_trip = (r_state == S_WAIT_DONE) && !Done && (r_wdog == c_WDOG_LAST);
`else
  assign w_wdog_trip = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      DIN     <= '0;
      Run     <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      Run <= 1'b0;
      if (w_launch) begin
        r_pc <= w_target_pc;
        if (r_state == S_IDLE || r_state == S_HALT) begin
          r_len <= prog_len;
          err   <= 1'b0;
        end
        if (w_at_end) begin
          r_state <= S_HALT;
          busy    <= 1'b0;
          halted  <= 1'b1;
        end else begin
          // A trailing mvi without its immediate is presented but not issued.
          r_state <= S_ISSUE;
          DIN     <= w_word;
          Run     <= !w_issue_missing;
          busy    <= 1'b1;
          halted  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_ISSUE: begin
            if (w_cur_missing) begin
              r_state <= S_HALT;
              err     <= 1'b1;
              busy    <= 1'b0;
              halted  <= 1'b1;
            end else begin
              r_pc <= w_pc_inc;
              if (DIN[8:6] == c_OP_MVI) begin
                r_state <= S_IMM;
                DIN     <= w_imm_word;
              end else begin
                r_state <= S_WAIT_DONE;
              end
            end
          end
          S_IMM: begin
            r_pc    <= w_pc_inc;
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (w_wdog_trip) begin
              r_state <= S_HALT;
              err     <= 1'b1;
              busy    <= 1'b0;
              halted  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alimentador_instrucoes.sv
// ============================================================================
// Module      : tb_alimentador_instrucoes
// Description : Directed self-checking bench for alimentador_instrucoes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alimentador_instrucoes;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  logic [5:0]  prog_len;
  logic        start;
  logic        Done;
  logic [15:0] DIN;
  logic        Run;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;
  int run_cnt = 0;
  int base;
  logic prev_run = 1'b0;

  alimentador_instrucoes #(
    .DATA_W(16), .ADDR_W(5), .WDOG_CYCLES(4)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .prog_len(prog_len), .start(start), .Done(Done),
    .DIN(DIN), .Run(Run), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run pulse counter and back-to-back Run check
  always @(negedge Clock) begin
    if (Run) run_cnt++;
    if (Resetn === 1'b1) chk("run_consecutive", {31'd0, Run & prev_run}, 32'd0);
    prev_run = Run;
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic start_prog(input logic [5:0] len);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic hold_wait(input int n, input logic [15:0] exp_din);
    for (int i = 0; i < n; i++) begin
      step();
      chk("wait_run", {31'd0, Run}, 32'd0);
      chk("wait_din", {16'd0, DIN}, {16'd0, exp_din});
    end
  endtask

  task automatic wait_halt(input int limit);
    int k = 0;
    while (!halted && k < limit) begin
      step();
      k++;
    end
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    Resetn = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    prog_len = '0; start = 1'b0; Done = 1'b0;
    step(); step();
    chk("rst_din", {16'd0, DIN}, 32'd0);
    chk("rst_run", {31'd0, Run}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_flags", {29'd0, busy, halted, err}, 32'd0);
    Resetn = 1'b1;
    step();

    // single-word instruction
    load(5'd0, 16'h0008);
    base = run_cnt;
    start_prog(6'd1);
    chk("t2_run", {31'd0, Run}, 32'd1);
    chk("t2_din", {16'd0, DIN}, 32'h0008);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t2_wait_run", {31'd0, Run}, 32'd0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t2_halted", {31'd0, halted}, 32'd1);
    chk("t2_pc", {27'd0, pc}, 32'd1);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_runs", run_cnt - base, 32'd1);

    // mvi with Done in the IMM cycle
    load(5'd0, 16'h0040);
    load(5'd1, 16'd5);
    start_prog(6'd2);
    chk("t3_run", {31'd0, Run}, 32'd1);
    chk("t3_din", {16'd0, DIN}, 32'h0040);
    step();
    chk("t3_imm_din", {16'd0, DIN}, 32'h0005);
    chk("t3_imm_run", {31'd0, Run}, 32'd0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t3_halted", {31'd0, halted}, 32'd1);
    chk("t3_pc", {27'd0, pc}, 32'd2);

    // trailing mvi without immediate, load attempt while busy
    base = run_cnt;
    start_prog(6'd1);
    chk("t4_run", {31'd0, Run}, 32'd0);
    chk("t4_din", {16'd0, DIN}, 32'h0040);
    ld_en = 1'b1; ld_addr = 5'd0; ld_data = 16'hFFFF;
    step();
    ld_en = 1'b0;
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_runs", run_cnt - base, 32'd0);
    start_prog(6'd1);
    chk("t4_readback", {16'd0, DIN}, 32'h0040);
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    step();
    chk("t4_err_again", {31'd0, err}, 32'd1);

    // empty program
    start_prog(6'd0);
    chk("t0_halted", {31'd0, halted}, 32'd1);
    chk("t0_err", {31'd0, err}, 32'd0);
    chk("t0_busy", {31'd0, busy}, 32'd0);
    chk("t0_run", {31'd0, Run}, 32'd0);

    // full-depth program, Done held high
    for (int i = 0; i < 32; i++) load(5'(i), 16'h0100 | 16'(i));
    Done = 1'b1;
    base = run_cnt;
    start_prog(6'd32);
    wait_halt(200);
    Done = 1'b0;
    chk("t32_runs", run_cnt - base, 32'd32);
    chk("t32_pc", {27'd0, pc}, 32'd0);
    chk("t32_din", {16'd0, DIN}, 32'h011F);
    chk("t32_err", {31'd0, err}, 32'd0);

    // three instructions, Done delayed 10 cycles each
    load(5'd0, 16'h0008);
    load(5'd1, 16'h0040);
    load(5'd2, 16'h0007);
    load(5'd3, 16'h0081);
    base = run_cnt;
    start_prog(6'd4);
    chk("t5_run0", {31'd0, Run}, 32'd1);
    chk("t5_din0", {16'd0, DIN}, 32'h0008);
    hold_wait(10, 16'h0008);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t5_run1", {31'd0, Run}, 32'd1);
    chk("t5_din1", {16'd0, DIN}, 32'h0040);
    chk("t5_pc1", {27'd0, pc}, 32'd1);
    step();
    chk("t5_imm", {16'd0, DIN}, 32'h0007);
    chk("t5_imm_pc", {27'd0, pc}, 32'd2);
    hold_wait(10, 16'h0007);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t5_run2", {31'd0, Run}, 32'd1);
    chk("t5_din2", {16'd0, DIN}, 32'h0081);
    hold_wait(10, 16'h0081);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_pc", {27'd0, pc}, 32'd4);
    chk("t5_runs", run_cnt - base, 32'd3);
    chk("t5_din_hold", {16'd0, DIN}, 32'h0081);

    // restart, then asynchronous reset in WAIT_DONE
    start_prog(6'd4);
    chk("t5r_run", {31'd0, Run}, 32'd1);
    chk("t5r_din", {16'd0, DIN}, 32'h0008);
    chk("t5r_pc", {27'd0, pc}, 32'd0);
    step();
    #2 Resetn = 1'b0;
    #1;
    chk("arst_din", {16'd0, DIN}, 32'd0);
    chk("arst_run", {31'd0, Run}, 32'd0);
    chk("arst_pc", {27'd0, pc}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    step();
    Resetn = 1'b1;
    step();

    // Done never arrives; memory survives reset
    start_prog(6'd1);
    chk("t6_din", {16'd0, DIN}, 32'h0008);
    step();
`ifdef FEEDER_WATCHDOG_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_wd_busy", {31'd0, busy}, 32'd1);
    end
    step();
    chk("t6_wd_halted", {31'd0, halted}, 32'd1);
    chk("t6_wd_err", {31'd0, err}, 32'd1);
`else
    repeat (100) step();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_halted", {31'd0, halted}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alimentador_instrucoes.md
Name: alimentador_instrucoes

Overview:
- Upstream instruction feeder for processador_multiciclo.
- Holds a small loadable program memory and walks a program counter through it.
- Drives the processor's DIN/Run inputs: one Run pulse per instruction, immediate word on DIN in the following cycle for mvi, then waits for Done before issuing the next word.
- Replaces hand-driven DIN/Run stimulus in the processor testbench and on the FPGA top level.

Parameters:
- DATA_W, 16, word width of DIN and program memory.
- ADDR_W, 5, program memory address width; depth = 2**ADDR_W.
- WDOG_CYCLES, 64, cycles allowed in WAIT_DONE before watchdog trip (only with FEEDER_WATCHDOG_EN).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- ld_en  in  1  program memory write strobe.
- ld_addr  in  ADDR_W  write address.
- ld_data  in  DATA_W  write data.
- prog_len  in  ADDR_W+1  number of words in program (0..2**ADDR_W); sampled on start.
- start  in  1  begin execution from address 0.
- Done  in  1  processor instruction-complete flag.
- DIN  out  DATA_W  word presented to processor.
- Run  out  1  instruction-issue pulse to processor.
- pc  out  ADDR_W  address of next word to fetch.
- busy  out  1  high in ISSUE, IMM, WAIT_DONE.
- halted  out  1  high in HALT.
- err  out  1  sticky error flag, cleared on start or reset.

Behaviour:
- Clock and reset:
  - One clock. Resetn is asynchronous and active-low; all state is clocked on Clock rising edge.
  - Reset (also mid-program): state=IDLE, pc=0, DIN=0, Run=0, busy=0, halted=0, err=0, latched length=0.
  - Memory contents are not reset.
- Memory:
  - Array of 2**ADDR_W x DATA_W, asynchronous read.
  - Written on Clock when ld_en=1, only in IDLE or HALT; ld_en in other states is ignored.
- Outputs: registered, updated on the edge that enters each state.
- Decode: opcode = DIN[8:6]. Opcode 3'b001 (mvi) is the only two-word instruction.
- IDLE: Run=0, DIN=0.
  - start=1 with prog_len!=0: latch prog_len, pc=0, err=0, go to ISSUE.
  - start=1 with prog_len=0: go to HALT, err=0.
- ISSUE (exactly 1 cycle): DIN=mem[pc], Run=1. Done is ignored.
  - If opcode=001 and pc=len-1 (immediate missing): do not issue (Run stays 0), set err=1, go to HALT.
  - Otherwise pc=pc+1. Opcode 001 goes to IMM; any other opcode goes to WAIT_DONE.
- IMM (exactly 1 cycle): DIN=mem[pc] (immediate), Run=0, pc=pc+1.
  - Done=1 in this cycle counts as completion and goes straight to next-issue logic.
  - Otherwise go to WAIT_DONE.
- WAIT_DONE: DIN holds last driven word, Run=0. On Done=1, apply next-issue logic.
- Next-issue logic: if pc==len, go to HALT; else go to ISSUE.
- HALT: halted=1, Run=0, DIN holds last word. start=1 restarts exactly as from IDLE.
- Run is never high in two consecutive cycles.
- pc arithmetic: ADDR_W bits. pc==len is compared in ADDR_W+1 bits, so len=2**ADDR_W halts after the last address without wrap.
- start while busy: ignored.
- Done outside IMM/WAIT_DONE: ignored.
- Minimum issue spacing: ISSUE, then WAIT_DONE with Done at T1, then ISSUE = 3 cycles for a 1-cycle instruction.

Optional Feature:
- Macro: FEEDER_WATCHDOG_EN.
- Defined:
  - Counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches WDOG_CYCLES without Done: set err=1, go to HALT.
  - Counter width is clog2(WDOG_CYCLES+1).
- Undefined: no counter; WAIT_DONE waits indefinitely; err is set only by the missing-immediate case.

Test Plan:
- Reset mid-WAIT_DONE: deassert Resetn asynchronously -> DIN=0, Run=0, pc=0, busy=0 immediately, without waiting for a Clock edge.
- Load mem[0]=16'h0008 (mv R1,R0), len=1, start; model returns Done one cycle after Run -> one Run pulse with DIN=0008, then halted=1, pc=1, err=0.
- Load mem[0]=16'h0040 (mvi R0), mem[1]=16'd5, len=2 -> ISSUE DIN=0040 Run=1; next cycle DIN=0005 Run=0; Done in IMM cycle -> HALT, pc=2.
- mem[0]=16'h0040, len=1 -> no Run pulse, err=1, halted=1; ld_en while busy leaves memory unchanged (read back after halt).
- Done delayed 10 cycles per instruction, 3-instruction program -> DIN stable and Run low throughout each wait; exactly 3 Run pulses; restart via start reruns from pc=0.
- FEEDER_WATCHDOG_EN with WDOG_CYCLES=4, Done never asserted -> err=1, HALT entered 4 cycles after WAIT_DONE entry; with macro undefined -> busy stays 1 indefinitely.
